// File: rtl/io_channel_hub.sv
// io_channel_hub: buffers the CPU's request/acknowledge I/O handshakes against
// up to 8 valid/ready peripheral channels. Each channel has one input FIFO
// (device to CPU) and one output FIFO (CPU to device).

// Single-clock FIFO. A push is refused when full, even if a pop happens in
// the same cycle. There is no fall-through path from push to head.
module io_channel_hub_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // The storage array needs no reset. The count alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module io_channel_hub #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      inp_req,
    input  logic [2:0]                inp_ch,
    output logic                      inp_ack,
    output logic [WIDTH-1:0]          inp_data,
    input  logic                      out_req,
    input  logic [2:0]                out_ch,
    input  logic [WIDTH-1:0]          out_data,
    output logic                      out_ack,
    input  logic [CHANNELS-1:0]       dev_in_valid,
    input  logic [CHANNELS*WIDTH-1:0] dev_in_data,
    output logic [CHANNELS-1:0]       dev_in_ready,
    output logic [CHANNELS-1:0]       dev_out_valid,
    output logic [CHANNELS*WIDTH-1:0] dev_out_data,
    input  logic [CHANNELS-1:0]       dev_out_ready,
    output logic [CHANNELS-1:0]       in_empty,
    output logic [CHANNELS-1:0]       out_full,
    output logic [1:0]                err,
    input  logic                      err_clr
);
    localparam logic [1:0] I_IDLE = 2'd0;
    localparam logic [1:0] I_ACK  = 2'd1;
    localparam logic [1:0] I_DROP = 2'd2;
    localparam logic [1:0] O_IDLE = 2'd0;
    localparam logic [1:0] O_ACK  = 2'd1;
    localparam logic [1:0] O_DROP = 2'd2;
    localparam logic [3:0] NCH    = 4'(CHANNELS);

    logic [1:0] i_st;
    logic [1:0] o_st;
    logic [1:0] err_next;

    logic [CHANNELS-1:0]            in_full;
    logic [CHANNELS-1:0]            in_pop;
    logic [CHANNELS-1:0]            out_push;
    logic [CHANNELS-1:0]            out_empty;
    logic [CHANNELS-1:0][WIDTH-1:0] in_head;

    logic             inp_bad;
    logic             out_bad;
    logic             sel_in_empty;
    logic             sel_out_full;
    logic [WIDTH-1:0] sel_in_head;
    logic             i_take;
    logic             o_take;
    logic             i_err;
    logic             o_err;

    assign inp_bad = ({1'b0, inp_ch} >= NCH);
    assign out_bad = ({1'b0, out_ch} >= NCH);

    // Select the FIFO status and head for the requested channel. Channels
    // that do not exist look empty or full, but they are handled separately.
    always_comb begin
        sel_in_empty = 1'b1;
        sel_out_full = 1'b1;
        sel_in_head  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (inp_ch == 3'(k)) begin
                sel_in_empty = in_empty[k];
                sel_in_head  = in_head[k];
            end
            if (out_ch == 3'(k)) sel_out_full = out_full[k];
        end
    end

    assign i_take = (i_st == I_IDLE) & inp_req & ~inp_bad & ~sel_in_empty;
    assign o_take = (o_st == O_IDLE) & out_req & ~out_bad & ~sel_out_full;
    assign i_err  = (i_st == I_IDLE) & inp_req & inp_bad;
    assign o_err  = (o_st == O_IDLE) & out_req & out_bad;

    assign inp_ack = (i_st == I_ACK);
    assign out_ack = (o_st == O_ACK);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign in_pop[k]        = i_take & (inp_ch == 3'(k));
        assign out_push[k]      = o_take & (out_ch == 3'(k));
        assign dev_in_ready[k]  = ~in_full[k] & ~rst_b;
        assign dev_out_valid[k] = ~out_empty[k];

        io_channel_hub_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
            .clk       (clk),
            .rst       (rst_b),
            .push      (dev_in_valid[k] & dev_in_ready[k]),
            .push_data (dev_in_data[k*WIDTH +: WIDTH]),
            .pop       (in_pop[k]),
            .head      (in_head[k]),
            .empty     (in_empty[k]),
            .full      (in_full[k])
        );

        io_channel_hub_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
            .clk       (clk),
            .rst       (rst_b),
            .push      (out_push[k]),
            .push_data (out_data),
            .pop       (dev_out_valid[k] & dev_out_ready[k]),
            .head      (dev_out_data[k*WIDTH +: WIDTH]),
            .empty     (out_empty[k]),
            .full      (out_full[k])
        );
    end

    // Input handshake: pop the word once, ack for one cycle, then wait for
    // the request to drop.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            i_st     <= I_IDLE;
            inp_data <= '0;
        end else begin
            case (i_st)
                I_IDLE: begin
                    if (i_err) begin
                        i_st     <= I_ACK;
                        inp_data <= '0;
                    end else if (i_take) begin
                        i_st     <= I_ACK;
                        inp_data <= sel_in_head;
                    end
                end
                I_ACK:   i_st <= I_DROP;
                I_DROP:  if (!inp_req) i_st <= I_IDLE;
                default: i_st <= I_IDLE;
            endcase
        end
    end

    // Output handshake. Writes to channels that do not exist are acked and
    // the word is discarded.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            o_st <= O_IDLE;
        end else begin
            case (o_st)
                O_IDLE:  if (o_err || o_take) o_st <= O_ACK;
                O_ACK:   o_st <= O_DROP;
                O_DROP:  if (!out_req) o_st <= O_IDLE;
                default: o_st <= O_IDLE;
            endcase
        end
    end

    // Sticky error flags. A new error on the clearing edge keeps its bit set.
    always_comb begin
        err_next = err;
        if (err_clr) err_next = 2'b00;
        if (i_err)   err_next[0] = 1'b1;
        if (o_err)   err_next[1] = 1'b1;
    end

    // Register the error flags.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) err <= 2'b00;
        else       err <= err_next;
    end
endmodule
